// File: rtl/ALU_package.sv
// ALU_package: shared opcode encoding and default operand width for the pipelined ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ALU_package;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    AND   = 3'd2,
    OR    = 3'd3,
    XOR   = 3'd4,
    NEG_A = 3'd5,
    ACC   = 3'd6,
    CLR   = 3'd7
  } opcode_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational opcode decode, sign extension, result, accumulator next-value and flags.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when results and acc_nxt are committed.
// Build option: ALU_SAT_EN makes ACC saturate and adds the sat output.
module alu_core
  import ALU_package::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  opcode_t                  opcode,
  input  logic signed [WIDTH-1:0]  a,
  input  logic signed [WIDTH-1:0]  b,
  input  logic signed [WIDTH:0]    acc,
  output logic signed [WIDTH:0]    res,
  output logic                     zero,
  output logic                     neg,
  output logic                     acc_we,
  output logic signed [WIDTH:0]    acc_nxt
`ifdef ALU_SAT_EN
  ,
  output logic                     sat
`endif
);

  localparam int OUT_W = WIDTH + 1;

  logic signed [OUT_W-1:0] sa;
  logic signed [OUT_W-1:0] sb;
  logic signed [OUT_W-1:0] acc_sum;

  // One extra bit of headroom makes ADD/SUB/NEG_A exact for every operand pair.
  assign sa = {a[WIDTH-1], a};
  assign sb = {b[WIDTH-1], b};

`ifdef ALU_SAT_EN
  logic signed [OUT_W:0] acc_wide;
  logic                  acc_ovf;

  assign acc_wide = {acc[OUT_W-1], acc} + {sa[OUT_W-1], sa};
  assign acc_ovf  = acc_wide[OUT_W] != acc_wide[OUT_W-1];
  // On overflow the wide sign bit says which rail was crossed.
  assign acc_sum  = !acc_ovf        ? acc_wide[OUT_W-1:0] :
                    acc_wide[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                      {1'b0, {(OUT_W-1){1'b1}}};
  assign sat      = (opcode == ACC) && acc_ovf;
`else
  // Plain OUT_W addition: wraps modulo 2^OUT_W.
  assign acc_sum = acc + sa;
`endif

  // Result and accumulator next-value per opcode; unknown encodings give 0 and leave acc alone.
  always_comb begin
    res     = '0;
    acc_we  = 1'b0;
    acc_nxt = acc;
    case (opcode)
      ADD:     res = sa + sb;
      SUB:     res = sa - sb;
      AND:     res = sa & sb;
      OR:      res = sa | sb;
      XOR:     res = sa ^ sb;
      NEG_A:   res = -sa;
      ACC: begin
        acc_we  = 1'b1;
        acc_nxt = acc_sum;
        res     = acc_sum;
      end
      CLR: begin
        acc_we  = 1'b1;
        acc_nxt = '0;
        res     = '0;
      end
      default: res = '0;
    endcase
  end

  assign zero = (res == '0);
  assign neg  = res[OUT_W-1];

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined signed ALU with internal accumulator and zero/neg flags.
// Latency: operands presented in cycle t give valid_out in cycle t+2 (S1 then S2 register).
// Backpressure: ready_in = !s1_vld || !s2_vld || ready_out; C/flags hold while valid_out && !ready_out.
// Build option: ALU_SAT_EN selects a saturating accumulator and adds the registered sat output.
module alu_pipe
  import ALU_package::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  opcode_t                 opcode,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic signed [WIDTH:0]   C,
  output logic                    zero,
  output logic                    neg
`ifdef ALU_SAT_EN
  ,
  output logic                    sat
`endif
);

  localparam int OUT_W = WIDTH + 1;

  logic                    s1_vld;
  logic                    s2_vld;
  logic                    adv1;
  logic                    adv2;
  opcode_t                 s1_op;
  logic signed [WIDTH-1:0] s1_a;
  logic signed [WIDTH-1:0] s1_b;
  logic signed [OUT_W-1:0] acc;
  logic signed [OUT_W-1:0] core_res;
  logic signed [OUT_W-1:0] core_acc_nxt;
  logic                    core_zero;
  logic                    core_neg;
  logic                    core_acc_we;
`ifdef ALU_SAT_EN
  logic                    core_sat;
`endif

  // A stage may load when it is empty or its contents move forward this cycle.
  assign adv2      = !s2_vld || ready_out;
  assign adv1      = !s1_vld || adv2;
  assign ready_in  = adv1;
  assign valid_out = s2_vld;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .opcode  (s1_op),
    .a       (s1_a),
    .b       (s1_b),
    .acc     (acc),
    .res     (core_res),
    .zero    (core_zero),
    .neg     (core_neg),
    .acc_we  (core_acc_we),
    .acc_nxt (core_acc_nxt)
`ifdef ALU_SAT_EN
    ,
    .sat     (core_sat)
`endif
  );

  // S1: capture opcode/operands on an input transfer; empties when its op moves on with no new one.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_op  <= ADD;
      s1_a   <= '0;
      s1_b   <= '0;
    end else if (adv1) begin
      s1_vld <= valid_in;
      if (valid_in) begin
        s1_op <= opcode;
        s1_a  <= A;
        s1_b  <= B;
      end
    end
  end

  // S2 and accumulator: commit result/flags and the accumulator only as an op leaves S1.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld <= 1'b0;
      C      <= '0;
      zero   <= 1'b1;
      neg    <= 1'b0;
      acc    <= '0;
`ifdef ALU_SAT_EN
      sat    <= 1'b0;
`endif
    end else if (adv2) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        C    <= core_res;
        zero <= core_zero;
        neg  <= core_neg;
`ifdef ALU_SAT_EN
        sat  <= core_sat;
`endif
        if (core_acc_we) begin
          acc <= core_acc_nxt;
        end
      end
    end
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the 4-bit combinational ALU. Operand width is a generic `WIDTH`.
- Adds valid/ready handshakes on input and output, an internal signed accumulator, and zero/negative flags.
- Sits between the stimulus/sequencer and the result consumer. It is driven over the existing interface style (clk input to the interface, modports DUT/TEST).

Parameters:
- WIDTH, 4, signed operand width of A and B (2's complement), min 2.
- OUT_W, WIDTH+1, result/accumulator width; fixed derived value, not overridable.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- valid_in  input  1  operand/opcode transfer request
- ready_in  output  1  block can accept a transfer this cycle
- opcode  input  opcode_t  operation select
- A  input  WIDTH  signed operand A
- B  input  WIDTH  signed operand B
- valid_out  output  1  C/flags hold a valid result
- ready_out  input  1  consumer accepts result this cycle
- C  output  OUT_W  signed result
- zero  output  1  C == 0
- neg  output  1  C[OUT_W-1]

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous, active-high. All state is sampled on the rising edge.
- Reset values:
  - ready_in = 1 one cycle after the reset edge.
  - valid_out = 0, C = 0, zero = 1, neg = 0.
  - Accumulator = 0; both stage valid bits = 0.
- Handshake:
  - A transfer occurs when valid_in && ready_in; the output handshake completes when valid_out && ready_out.
  - Inputs are ignored when no transfer occurs.
- Pipeline:
  - S1 registers opcode/A/B; S2 registers the computed C/flags.
  - adv2 = !s2_v || ready_out.
  - adv1 = !s1_v || adv2.
  - ready_in = adv1.
  - Latency: 2 cycles from the accepting edge to valid_out.
  - Throughput: 1 op/cycle when ready_out is held high.
- Ordering and stall:
  - Results are strictly in accept order.
  - C/flags are held stable while valid_out && !ready_out.
- Arithmetic: all operations sign-extend to OUT_W first.
  - ADD: A+B. SUB: A-B. These are exact and never overflow.
  - AND, OR, XOR: bitwise on the sign-extended operands.
  - NEG_A: -A; -2^(WIDTH-1) is exact in OUT_W.
  - ACC: acc <= acc + sext(A); C = new acc.
  - CLR: acc <= 0; C = 0.
  - Undefined encoding: C = 0, accumulator unchanged.
- Accumulator timing:
  - The accumulator updates only when an ACC/CLR op moves S1 -> S2 (adv2 && s1_v).
  - Back-to-back ACC ops chain correctly with no bubble.
- Flags: zero and neg are computed from the S2 result and registered with C.
- Reset mid-operation: in-flight ops are discarded and the accumulator is cleared. No result for a pre-reset transfer ever appears.
- Simultaneous events: an input transfer and an output drain in the same cycle are both honoured.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: ACC saturates to +(2^(OUT_W-1)-1) / -(2^(OUT_W-1)), and a registered output `sat` (1 bit, reset 0) pulses with the result that clipped.
- Undefined: ACC wraps modulo 2^OUT_W, and the `sat` port does not exist.

Decomposition:
- Package `ALU_package`:
  - opcode_t enum: ADD, SUB, AND, OR, XOR, NEG_A, ACC, CLR; 3-bit logic base.
  - Default WIDTH constant.
- Sub-module `alu_core`: purely combinational opcode/sign-extension/result plus flag computation, parametrised by WIDTH.
- alu_pipe owns the stage registers, handshake logic and accumulator.

Test Plan (WIDTH=4, OUT_W=5):
1. ADD A=7 B=7, ready_out=1 -> valid_out 2 cycles later, C=14, zero=0, neg=0. SUB A=-8 B=7 -> C=-15, neg=1.
2. NEG_A A=-8 -> C=8. XOR A=5 B=5 -> C=0, zero=1.
3. CLR, then ACC A=7 three times back-to-back -> C=7, 14, then -11 (wrap); with ALU_SAT_EN the third result is C=15, sat=1.
4. Hold ready_out=0 while sending 3 ops -> exactly 2 accepted, ready_in=0, C stable. Release -> results drain in order, then the third op is accepted.
5. Assert reset with 2 ops in flight -> no valid_out for them, accumulator reads 0 via the next ACC A=1 (C=1).
6. valid_in toggling with ready_out random over 1000 ops -> scoreboard matches the golden model in order, no drops or duplicates.
